// File: rtl/btn_pkg.sv
// Shared button-handling definitions: debouncer FSM encoding and default timing
// constants, reused by the downstream single-pulse shaper.
package btn_pkg;

    typedef enum logic [1:0] {
        S_RELEASED     = 2'b00,
        S_PRESS_PEND   = 2'b01,
        S_PRESSED      = 2'b11,
        S_RELEASE_PEND = 2'b10
    } btn_state_e;

    localparam int DEF_DB_CYCLES     = 500000;
    localparam int DEF_HOLD_CYCLES   = 25000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;
    localparam int DEF_CNT_W         = 25;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw button line; idles at 1 (released) out of reset.
module btn_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Button debouncer: synchronizer + 4-state qualification FSM with a registered level out.
// Define BTN_AUTOREPEAT_EN to add auto-repeat blips on b_out while the button is held.
module button_debouncer
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_raw,
    output logic       b_out,
    output btn_state_e state_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    if (CNT_W < $clog2(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES))) begin : g_cnt_w_check
        $error("button_debouncer: CNT_W too narrow for the configured cycle counts");
    end

    logic             b_s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             b_out_q, b_out_d;

    btn_sync u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (b_raw),
        .q_o    (b_s)
    );

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rpt_q, rpt_d;
    logic [CNT_W-1:0] rpt_last;
    logic             first_q, first_d;

    assign rpt_last = first_q ? REPEAT_LAST : HOLD_LAST;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RELEASED: begin
                if (!b_s) begin
                    state_d = S_PRESS_PEND;
                    cnt_d   = '0;
                end
            end
            S_PRESS_PEND: begin
                if (b_s) begin
                    state_d = S_RELEASED;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PRESSED: begin
                if (b_s) begin
                    state_d = S_RELEASE_PEND;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_PEND: begin
                if (!b_s) begin
                    state_d = S_PRESSED;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_RELEASED;
                cnt_d   = '0;
            end
        endcase

        b_out_d = (state_d == S_RELEASED) || (state_d == S_PRESS_PEND);

`ifdef BTN_AUTOREPEAT_EN
        rpt_d   = rpt_q;
        first_d = first_q;
        // A release seen this cycle leaves S_PRESSED, so it always beats a blip.
        if (state_q == S_PRESSED && state_d == S_PRESSED) begin
            if (b_out_q) begin
                rpt_d = '0;
            end else if (rpt_q == rpt_last) begin
                rpt_d   = '0;
                first_d = 1'b1;
                b_out_d = 1'b1;
            end else begin
                rpt_d = rpt_q + CNT_W'(1);
            end
        end else begin
            rpt_d   = '0;
            first_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RELEASED;
            cnt_q   <= '0;
            b_out_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_out_q <= b_out_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            rpt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            rpt_q   <= rpt_d;
            first_q <= first_d;
        end
    end
`endif

    assign b_out   = b_out_q;
    assign state_o = state_q;

endmodule
